// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver: FSM encoding, parity
// modes and helpers for deriving bit timing.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_CLEANUP   = 3'd5,
    ST_WAIT_HIGH = 3'd6
  } state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Rounded to the nearest whole clock so the bit-period error stays below half a clock.
  function automatic int clks_per_bit(input longint clk_hz, input longint baud);
    return int'((clk_hz + baud / 2) / baud);
  endfunction

  function automatic int cnt_width(input int cpb);
    return (cpb <= 2) ? 1 : $clog2(cpb);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: one strobe at mid start bit, then one strobe per bit period
// so every later sample lands mid-bit. Holding clear restarts the sequence.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  output logic half_tick,
  output logic full_tick
);

  localparam int W = cnt_width(CLKS_PER_BIT);
  localparam logic [W-1:0] HALF_MAX = W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [W-1:0] FULL_MAX = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt_reg;
  logic         half_done_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg       <= '0;
      half_done_reg <= 1'b0;
    end else if (clear) begin
      cnt_reg       <= '0;
      half_done_reg <= 1'b0;
    end else if (!half_done_reg) begin
      if (cnt_reg == HALF_MAX) begin
        cnt_reg       <= '0;
        half_done_reg <= 1'b1;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end else if (cnt_reg == FULL_MAX) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign half_tick = !half_done_reg && (cnt_reg == HALF_MAX);
  assign full_tick = half_done_reg && (cnt_reg == FULL_MAX);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: synchronised RX line, mid-bit sampling, optional
// parity, 1 or 2 stop bits, with parity/framing/break reporting.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10417,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 uart_rx,
  output logic                 rx_dv,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_break
);

  if (CLKS_PER_BIT < 4) begin : g_bad_cpb
    $error("uart_rx_cfg: CLKS_PER_BIT must be >= 4");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_rx_cfg: DATA_BITS must be 5..9");
  end
  if (PARITY != PARITY_NONE && PARITY != PARITY_ODD && PARITY != PARITY_EVEN) begin : g_bad_parity
    $error("uart_rx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
  end

  localparam logic       PAR_EN     = (PARITY != PARITY_NONE);
  localparam logic       PAR_EXPECT = (PARITY == PARITY_ODD);
  localparam logic [3:0] LAST_DATA  = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP  = 4'(STOP_BITS - 1);

  logic                 sync_meta_reg;
  logic                 rx_s;
  state_t               state_reg;
  logic [3:0]           bit_cnt_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_bit_reg;
  logic                 stop_err_reg;
  logic                 timer_clear;
  logic                 half_tick;
  logic                 full_tick;
  logic                 frame_bad;
  logic                 par_bad;
  logic                 break_now;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta_reg <= 1'b1;
      rx_s          <= 1'b1;
    end else begin
      sync_meta_reg <= uart_rx;
      rx_s          <= sync_meta_reg;
    end
  end

  // Timer only runs while a frame is in progress, so it starts at zero on the start edge.
  assign timer_clear = (state_reg != ST_START) && (state_reg != ST_DATA) &&
                       (state_reg != ST_PARITY) && (state_reg != ST_STOP);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (timer_clear),
    .half_tick(half_tick),
    .full_tick(full_tick)
  );

  // Evaluated at the final stop sample, folding in the bit being sampled right now.
  assign frame_bad = stop_err_reg | ~rx_s;
  assign par_bad   = PAR_EN && ((^shift_reg ^ par_bit_reg) != PAR_EXPECT);
  assign break_now = frame_bad && (shift_reg == '0) && !par_bit_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      par_bit_reg   <= 1'b0;
      stop_err_reg  <= 1'b0;
      rx_dv         <= 1'b0;
      rx_data       <= '0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_break      <= 1'b0;
    end else begin
      rx_dv <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          bit_cnt_reg  <= '0;
          par_bit_reg  <= 1'b0;
          stop_err_reg <= 1'b0;
          if (!rx_s) state_reg <= ST_START;
        end
        ST_START: begin
          if (half_tick) state_reg <= rx_s ? ST_IDLE : ST_DATA;
        end
        ST_DATA: begin
          if (full_tick) begin
            shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
            if (bit_cnt_reg == LAST_DATA) begin
              bit_cnt_reg <= '0;
              state_reg   <= PAR_EN ? ST_PARITY : ST_STOP;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (full_tick) begin
            par_bit_reg <= rx_s;
            state_reg   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (full_tick) begin
            if (bit_cnt_reg == LAST_STOP) begin
              rx_dv         <= 1'b1;
              rx_data       <= shift_reg;
              rx_parity_err <= par_bad;
              rx_frame_err  <= frame_bad;
              rx_break      <= break_now;
              bit_cnt_reg   <= '0;
              state_reg     <= frame_bad ? ST_WAIT_HIGH : ST_CLEANUP;
            end else begin
              stop_err_reg <= frame_bad;
              bit_cnt_reg  <= bit_cnt_reg + 1'b1;
            end
          end
        end
        ST_CLEANUP: state_reg <= ST_IDLE;
        // A held-low line (break) must return high before another frame is accepted.
        ST_WAIT_HIGH: begin
          if (rx_s) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: three configurations (8N1, 8E1, 5N2) driven by
// directed frames; a per-clock monitor pops expected results on every rx_dv.
module tb_uart_rx_cfg;

  localparam int CPB = 16;

  typedef struct packed {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n = 1'b1;
  logic reset_c = 1'b1;
  logic line_a = 1'b1, line_p = 1'b1, line_c = 1'b1;

  logic       dv_a, perr_a, ferr_a, brk_a;
  logic [7:0] data_a;
  logic       dv_p, perr_p, ferr_p, brk_p;
  logic [7:0] data_p;
  logic       dv_c, perr_c, ferr_c, brk_c;
  logic [4:0] data_c;

  exp_t q_a[$], q_p[$], q_c[$];
  int   checks = 0;
  int   errors = 0;
  int   pushed[3] = '{0, 0, 0};
  int   seen[3] = '{0, 0, 0};

  always #5 clock = ~clock;

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .clock(clock), .reset_n(reset_n), .uart_rx(line_a), .rx_dv(dv_a), .rx_data(data_a),
    .rx_parity_err(perr_a), .rx_frame_err(ferr_a), .rx_break(brk_a));

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_p (
    .clock(clock), .reset_n(reset_n), .uart_rx(line_p), .rx_dv(dv_p), .rx_data(data_p),
    .rx_parity_err(perr_p), .rx_frame_err(ferr_p), .rx_break(brk_p));

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2)) u_c (
    .clock(clock), .reset_n(reset_c), .uart_rx(line_c), .rx_dv(dv_c), .rx_data(data_c),
    .rx_parity_err(perr_c), .rx_frame_err(ferr_c), .rx_break(brk_c));

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int inst, input logic [8:0] d, input logic pe, input logic fe,
                      input logic br);
    exp_t e;
    e = '{data: d, perr: pe, ferr: fe, brk: br};
    case (inst)
      0:       q_a.push_back(e);
      1:       q_p.push_back(e);
      default: q_c.push_back(e);
    endcase
    pushed[inst]++;
  endtask

  task automatic on_dv(input int inst, input logic [8:0] d, input logic pe, input logic fe,
                       input logic br);
    exp_t e;
    int   depth;
    seen[inst]++;
    $display("rx[%0d] t=%0t data=0x%0h perr=%0b ferr=%0b brk=%0b", inst, $time, d, pe, fe, br);
    case (inst)
      0:       depth = q_a.size();
      1:       depth = q_p.size();
      default: depth = q_c.size();
    endcase
    if (depth == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_dv: inst %0d got data 0x%0h expected no frame", inst, d);
    end else begin
      case (inst)
        0:       e = q_a.pop_front();
        1:       e = q_p.pop_front();
        default: e = q_c.pop_front();
      endcase
      cmp($sformatf("rx_data[%0d]", inst), 32'(d), 32'(e.data));
      cmp($sformatf("rx_parity_err[%0d]", inst), 32'(pe), 32'(e.perr));
      cmp($sformatf("rx_frame_err[%0d]", inst), 32'(fe), 32'(e.ferr));
      cmp($sformatf("rx_break[%0d]", inst), 32'(br), 32'(e.brk));
    end
  endtask

  always @(negedge clock) begin
    if (dv_a === 1'b1) on_dv(0, {1'b0, data_a}, perr_a, ferr_a, brk_a);
    if (dv_p === 1'b1) on_dv(1, {1'b0, data_p}, perr_p, ferr_p, brk_p);
    if (dv_c === 1'b1) on_dv(2, {4'b0, data_c}, perr_c, ferr_c, brk_c);
  end

  task automatic drive(input int inst, input logic v);
    case (inst)
      0:       line_a = v;
      1:       line_p = v;
      default: line_c = v;
    endcase
  endtask

  // par < 0 means no parity bit; otherwise par[0] is the transmitted parity bit.
  task automatic send_frame(input int inst, input logic [8:0] d, input int nb, input int par,
                            input int nstop, input logic stop_v, input int gap);
    logic [31:0] seq;
    int          len;
    seq = '1;
    len = 0;
    seq[len] = 1'b0;
    len++;
    for (int i = 0; i < nb; i++) begin
      seq[len] = d[i];
      len++;
    end
    if (par >= 0) begin
      seq[len] = par[0];
      len++;
    end
    for (int i = 0; i < nstop; i++) begin
      seq[len] = stop_v;
      len++;
    end
    for (int i = 0; i < len; i++) begin
      drive(inst, seq[i]);
      repeat (CPB) @(posedge clock);
    end
    drive(inst, 1'b1);
    repeat (gap) @(posedge clock);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset_n = 1'b0;
    reset_c = 1'b0;
    #1;
    cmp("reset_outputs_a", 32'({dv_a, data_a, perr_a, ferr_a, brk_a}), 32'd0);
    cmp("reset_outputs_p", 32'({dv_p, data_p, perr_p, ferr_p, brk_p}), 32'd0);
    cmp("reset_outputs_c", 32'({dv_c, data_c, perr_c, ferr_c, brk_c}), 32'd0);
    repeat (3) @(posedge clock);
    reset_n = 1'b1;
    reset_c = 1'b1;
    repeat (5) @(posedge clock);

    // 8N1 clean frame
    push(0, 9'h0A5, 1'b0, 1'b0, 1'b0);
    send_frame(0, 9'h0A5, 8, -1, 1, 1'b1, 3 * CPB);

    // even parity: 0x3C has even weight, so parity 1 is wrong and 0 is right
    push(1, 9'h03C, 1'b1, 1'b0, 1'b0);
    send_frame(1, 9'h03C, 8, 1, 1, 1'b1, 3 * CPB);
    push(1, 9'h03C, 1'b0, 1'b0, 1'b0);
    send_frame(1, 9'h03C, 8, 0, 1, 1'b1, 3 * CPB);

    // framing error, then a clean frame
    push(0, 9'h055, 1'b0, 1'b1, 1'b0);
    send_frame(0, 9'h055, 8, -1, 1, 1'b0, 3 * CPB);
    push(0, 9'h00F, 1'b0, 1'b0, 1'b0);
    send_frame(0, 9'h00F, 8, -1, 1, 1'b1, 3 * CPB);

    // start glitch shorter than half a bit: no frame, receiver ready for the next one
    drive(0, 1'b0);
    repeat (4) @(posedge clock);
    drive(0, 1'b1);
    repeat (3 * CPB) @(posedge clock);
    push(0, 9'h0C3, 1'b0, 1'b0, 1'b0);
    send_frame(0, 9'h0C3, 8, -1, 1, 1'b1, 3 * CPB);

    // line break: exactly one frame reported, then normal reception
    push(0, 9'h000, 1'b0, 1'b1, 1'b1);
    drive(0, 1'b0);
    repeat (20 * CPB) @(posedge clock);
    drive(0, 1'b1);
    repeat (3 * CPB) @(posedge clock);
    push(0, 9'h081, 1'b0, 1'b0, 1'b0);
    send_frame(0, 9'h081, 8, -1, 1, 1'b1, 3 * CPB);

    // 5N2 back-to-back frames
    push(2, 9'h013, 1'b0, 1'b0, 1'b0);
    push(2, 9'h013, 1'b0, 1'b0, 1'b0);
    send_frame(2, 9'h013, 5, -1, 2, 1'b1, 0);
    send_frame(2, 9'h013, 5, -1, 2, 1'b1, 3 * CPB);

    // reset part-way through a third frame
    drive(2, 1'b0);
    repeat (3 * CPB) @(posedge clock);
    reset_c = 1'b0;
    drive(2, 1'b1);
    #1;
    cmp("midframe_reset_outputs_c", 32'({dv_c, data_c, perr_c, ferr_c, brk_c}), 32'd0);
    repeat (2) @(posedge clock);
    #1;
    cmp("held_reset_outputs_c", 32'({dv_c, data_c, perr_c, ferr_c, brk_c}), 32'd0);
    @(posedge clock);
    reset_c = 1'b1;
    repeat (4 * CPB) @(posedge clock);
    push(2, 9'h00A, 1'b0, 1'b0, 1'b0);
    send_frame(2, 9'h00A, 5, -1, 2, 1'b1, 3 * CPB);

    repeat (2 * CPB) @(posedge clock);
    for (int i = 0; i < 3; i++) begin
      cmp($sformatf("dv_count[%0d]", i), 32'(seen[i]), 32'(pushed[i]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
